perf_counter_bank: RTL and testbench

Parametrised hardware performance-counter bank, successor to the per-signal DIFFTEST perf counter. It provides NUM_COUNTERS programmable counters, each selecting one of NUM_EVENTS event sources. Each event delivers a multi-bit increment per cycle. The bank adds wide counters, sticky overflow with interrupt, and a register-style read/write port. It is instantiated once per core and fed by the frontend, backend and cache event buses.

---
 rtl/perf_counter_bank.sv | 176 +++++++++++++++++
 tb/tb_perf_counter_bank.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/perf_counter_bank.sv
// Performance-counter bank: NUM_COUNTERS wide counters, each selecting one multi-bit event input.
// Optional build macro PERF_SNAPSHOT_EN adds per-counter shadow registers for atomic snapshot reads.
module perf_counter_bank #(
  parameter int NUM_EVENTS   = 16,
  parameter int NUM_COUNTERS = 8,
  parameter int CNT_WIDTH    = 48,
  parameter int INC_WIDTH    = 3,
  parameter int ADDR_W       = $clog2(NUM_COUNTERS) + 2
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            global_en,
  input  logic [NUM_EVENTS*INC_WIDTH-1:0] evt_inc,
  input  logic                            wr_en,
  input  logic [ADDR_W-1:0]               wr_addr,
  input  logic [63:0]                     wr_data,
  input  logic                            rd_en,
  input  logic [ADDR_W-1:0]               rd_addr,
  output logic                            rd_valid,
  output logic [63:0]                     rd_data,
  output logic                            ovf_irq
);

  localparam int IDX_W = ADDR_W - 2;
  localparam logic [1:0] F_CNT = 2'd0;
  localparam logic [1:0] F_CFG = 2'd1;
  localparam logic [1:0] F_OVF = 2'd2;
  localparam logic [1:0] F_CTL = 2'd3;

  logic [INC_WIDTH-1:0] evt_arr [NUM_EVENTS];
  logic [CNT_WIDTH-1:0] cnt_vec [NUM_COUNTERS];
  logic [CNT_WIDTH-1:0] snap_vec [NUM_COUNTERS];
  logic [9:0]           cfg_vec [NUM_COUNTERS];
  logic [NUM_COUNTERS-1:0] ovf_vec;
  logic [NUM_COUNTERS-1:0] irq_en_vec;

  logic [IDX_W-1:0] wr_idx;
  logic [1:0]       wr_field;
  logic [IDX_W-1:0] rd_idx;
  logic [1:0]       rd_field;
  logic             ctl_wr;
  logic             clear_all;
  logic             snap_cmd;
  logic             unused_wr_bits;

  logic             rd_valid_reg;
  logic [63:0]      rd_data_reg;
  logic [63:0]      rd_data_next;
  logic             ovf_irq_reg;

  assign wr_idx    = wr_addr[ADDR_W-1:2];
  assign wr_field  = wr_addr[1:0];
  assign rd_idx    = rd_addr[ADDR_W-1:2];
  assign rd_field  = rd_addr[1:0];
  assign ctl_wr    = wr_en && (wr_field == F_CTL) && (wr_idx == '0);
  assign clear_all = ctl_wr && wr_data[1];
  assign unused_wr_bits = ^wr_data;

`ifdef PERF_SNAPSHOT_EN
  assign snap_cmd = ctl_wr && wr_data[0];
`else
  assign snap_cmd = 1'b0;
`endif

  genvar gi;
  generate
    for (gi = 0; gi < NUM_EVENTS; gi++) begin : g_evt
      assign evt_arr[gi] = evt_inc[gi*INC_WIDTH +: INC_WIDTH];
    end

    for (gi = 0; gi < NUM_COUNTERS; gi++) begin : g_cnt
      logic [CNT_WIDTH-1:0] cnt_reg;
      logic [7:0]           sel_reg;
      logic                 en_reg;
      logic                 irq_en_reg;
      logic                 ovf_reg;
      logic [INC_WIDTH-1:0] inc;
      logic [CNT_WIDTH:0]   sum;
      logic                 hit;
      logic                 cnt_wr;
      logic                 ovf_set;

      assign hit    = wr_en && (wr_idx == IDX_W'(gi));
      assign cnt_wr = hit && (wr_field == F_CNT);

      // Selectors beyond NUM_EVENTS match no input, so the counter holds.
      always_comb begin
        inc = '0;
        if (en_reg && global_en) begin
          for (int e = 0; e < NUM_EVENTS; e++) begin
            if (sel_reg == 8'(e)) inc = evt_arr[e];
          end
        end
      end

      assign sum     = {1'b0, cnt_reg} + {{(CNT_WIDTH+1-INC_WIDTH){1'b0}}, inc};
      // A carry only counts when the add is actually committed to the counter.
      assign ovf_set = sum[CNT_WIDTH] && !clear_all && !cnt_wr;

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          cnt_reg    <= '0;
          sel_reg    <= '0;
          en_reg     <= 1'b0;
          irq_en_reg <= 1'b0;
          ovf_reg    <= 1'b0;
        end else begin
          if (clear_all)   cnt_reg <= '0;
          else if (cnt_wr) cnt_reg <= wr_data[CNT_WIDTH-1:0];
          else             cnt_reg <= sum[CNT_WIDTH-1:0];

          if (ovf_set)                                       ovf_reg <= 1'b1;
          else if (hit && (wr_field == F_OVF) && wr_data[0]) ovf_reg <= 1'b0;

          if (hit && (wr_field == F_CFG)) begin
            sel_reg    <= wr_data[7:0];
            en_reg     <= wr_data[8];
            irq_en_reg <= wr_data[9];
          end
        end
      end

`ifdef PERF_SNAPSHOT_EN
      logic [CNT_WIDTH-1:0] snap_reg;
      always_ff @(posedge clk or negedge rst) begin
        if (!rst)          snap_reg <= '0;
        else if (snap_cmd) snap_reg <= cnt_reg;
      end
      assign snap_vec[gi] = snap_reg;
`else
      assign snap_vec[gi] = cnt_reg;
`endif

      assign cnt_vec[gi]    = cnt_reg;
      assign cfg_vec[gi]    = {irq_en_reg, en_reg, sel_reg};
      assign ovf_vec[gi]    = ovf_reg;
      assign irq_en_vec[gi] = irq_en_reg;
    end
  endgenerate

  // Read mux sees register state from before this edge, so same-cycle writes are not visible.
  always_comb begin
    rd_data_next = '0;
    if (int'(rd_idx) < NUM_COUNTERS) begin
      case (rd_field)
        F_CNT: begin
`ifdef PERF_SNAPSHOT_EN
          rd_data_next = 64'(snap_vec[rd_idx]);
`else
          rd_data_next = 64'(cnt_vec[rd_idx]);
`endif
        end
        F_CFG:   rd_data_next = 64'(cfg_vec[rd_idx]);
        F_OVF:   rd_data_next = 64'(ovf_vec[rd_idx]);
        default: rd_data_next = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_valid_reg <= 1'b0;
      rd_data_reg  <= '0;
      ovf_irq_reg  <= 1'b0;
    end else begin
      rd_valid_reg <= rd_en;
      if (rd_en) rd_data_reg <= rd_data_next;
      ovf_irq_reg  <= |(ovf_vec & irq_en_vec);
    end
  end

  assign rd_valid = rd_valid_reg;
  assign rd_data  = rd_data_reg;
  assign ovf_irq  = ovf_irq_reg;

endmodule

// File: tb/tb_perf_counter_bank.sv
// Self-checking bench for perf_counter_bank: read expectations are queued at issue time and
// compared when rd_valid returns. Build with PERF_SNAPSHOT_EN to exercise the shadow registers.
module tb_perf_counter_bank;

  localparam int NE = 16;
  localparam int NC = 8;
  localparam int CW = 48;
  localparam int IW = 3;
  localparam int AW = 5;

  logic           clk = 1'b0;
  logic           rst;
  logic           global_en;
  logic [NE*IW-1:0] evt_inc;
  logic           wr_en;
  logic [AW-1:0]  wr_addr;
  logic [63:0]    wr_data;
  logic           rd_en;
  logic [AW-1:0]  rd_addr;
  logic           rd_valid;
  logic [63:0]    rd_data;
  logic           ovf_irq;

  int total = 0;
  int bad   = 0;
  logic [63:0] exp_q [$];
  logic        exp_valid;

  perf_counter_bank #(
    .NUM_EVENTS(NE), .NUM_COUNTERS(NC), .CNT_WIDTH(CW), .INC_WIDTH(IW)
  ) dut (
    .clk(clk), .rst(rst), .global_en(global_en), .evt_inc(evt_inc),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_valid(rd_valid), .rd_data(rd_data), .ovf_irq(ovf_irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Read latency reference: valid one cycle after rd_en, dropped by reset.
  always @(posedge clk or negedge rst) begin
    if (!rst) exp_valid <= 1'b0;
    else      exp_valid <= rd_en;
  end

  always @(negedge clk) begin
    chk("rd_valid", rd_valid, exp_valid);
    if (rd_valid) begin
      if (exp_q.size() == 0) chk("rd_unexpected", 1, 0);
      else begin
        logic [63:0] e;
        e = exp_q.pop_front();
        chk("rd_data", rd_data, e);
        $display("read data=%h exp=%h", rd_data, e);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int idx, input int f, input logic [63:0] d);
    wr_en = 1'b1; wr_addr = AW'(idx*4 + f); wr_data = d;
    step();
    wr_en = 1'b0;
  endtask

  task automatic rd(input int idx, input int f, input logic [63:0] e);
    rd_en = 1'b1; rd_addr = AW'(idx*4 + f);
    exp_q.push_back(e);
    step();
    rd_en = 1'b0;
  endtask

  // Count reads: in the snapshot build, refresh the shadows first.
  task automatic rd_cnt(input int idx, input logic [63:0] e);
`ifdef PERF_SNAPSHOT_EN
    wr(0, 3, 64'd1);
`endif
    rd(idx, 0, e);
  endtask

  task automatic set_evt(input int e, input int v);
    evt_inc[e*IW +: IW] = IW'(v);
  endtask

  initial begin
    rst = 1'b0; global_en = 1'b0; evt_inc = '0;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0; rd_en = 1'b0; rd_addr = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("irq_in_reset", ovf_irq, 0);
    rst = 1'b1;
    step();
    chk("irq_after_reset", ovf_irq, 0);

    // Every field of every counter reads 0 after reset, back-to-back.
    for (int i = 0; i < NC; i++)
      for (int f = 0; f < 4; f++) rd(i, f, 64'd0);
    repeat (2) step();

    // Basic counting and the global freeze.
    wr(2, 1, 64'h105);
    global_en = 1'b1; set_evt(5, 3);
    repeat (10) step();
    set_evt(5, 0);
    rd_cnt(2, 64'd30);
    global_en = 1'b0; set_evt(5, 3);
    repeat (10) step();
    rd_cnt(2, 64'd30);
    set_evt(5, 0); global_en = 1'b1;
    rd(2, 1, 64'h105);
    rd_cnt(3, 64'd0);

    // Wrap, sticky overflow and interrupt latency.
    wr(0, 0, 64'h0000_FFFF_FFFF_FFFE);
    wr(0, 1, 64'h307);
    set_evt(7, 4);
    step();
    set_evt(7, 0);
    chk("irq_not_yet", ovf_irq, 0);
    step();
    chk("irq_set", ovf_irq, 1);
    rd_cnt(0, 64'd2);
    rd(0, 2, 64'd1);
    wr(0, 2, 64'd1);
    chk("irq_clear_lat", ovf_irq, 1);
    step();
    chk("irq_cleared", ovf_irq, 0);
    rd(0, 2, 64'd0);
    wr(0, 0, 64'h0000_FFFF_FFFF_FFFF);
    wr_en = 1'b1; wr_addr = AW'(0*4 + 2); wr_data = 64'd1; set_evt(7, 1);
    step();
    wr_en = 1'b0; set_evt(7, 0);
    rd(0, 2, 64'd1);
    rd_cnt(0, 64'd0);
    chk("irq_set_wins", ovf_irq, 1);
    wr(0, 1, 64'h107);
    chk("irq_en_drop_lat", ovf_irq, 1);
    step();
    chk("irq_en_dropped", ovf_irq, 0);
    wr(0, 1, 64'h0);

    // Count write beats increment; same-cycle read/write ordering.
    wr(1, 1, 64'h103);
    wr_en = 1'b1; wr_addr = AW'(1*4); wr_data = 64'd100; set_evt(3, 7);
    step();
    wr_en = 1'b0; set_evt(3, 0);
    rd_cnt(1, 64'd100);
    wr_en = 1'b1; wr_addr = AW'(1*4); wr_data = 64'd555;
    rd_en = 1'b1; rd_addr = AW'(1*4); exp_q.push_back(64'd100);
    step();
    wr_en = 1'b0; rd_en = 1'b0;
    rd_cnt(1, 64'd555);
    wr_en = 1'b1; wr_addr = AW'(1*4); wr_data = 64'd777;
    rd_en = 1'b1; rd_addr = AW'(2*4); exp_q.push_back(64'd30);
    step();
    wr_en = 1'b0; rd_en = 1'b0;
    rd_cnt(1, 64'd777);

    // Out-of-range selector holds; clear-all spares ovf and config.
    wr(1, 1, 64'h0);
    wr(3, 0, 64'd10);
    wr(3, 1, 64'h1C8);
    evt_inc = '1;
    repeat (5) step();
    evt_inc = '0;
    rd_cnt(3, 64'd10);
    rd_cnt(2, 64'd65);
    rd_cnt(1, 64'd777);
    rd(3, 1, 64'h1C8);
    wr(0, 3, 64'd2);
    rd_cnt(2, 64'd0);
    rd_cnt(3, 64'd0);
    rd_cnt(1, 64'd0);
    rd(0, 2, 64'd1);
    rd(2, 1, 64'h105);
    rd(0, 3, 64'd0);
    wr(0, 2, 64'd1);

    // Snapshot combined with clear-all.
    wr(2, 0, 64'd50);
    wr(3, 0, 64'd60);
    wr(0, 3, 64'd3);
`ifdef PERF_SNAPSHOT_EN
    rd(2, 0, 64'd50);
    rd(3, 0, 64'd60);
`else
    rd(2, 0, 64'd0);
    rd(3, 0, 64'd0);
`endif
    set_evt(5, 3);
    repeat (2) step();
    set_evt(5, 0);
`ifdef PERF_SNAPSHOT_EN
    rd(2, 0, 64'd50);
    wr(0, 3, 64'd1);
`endif
    rd(2, 0, 64'd6);
    rd(3, 0, 64'd0);
    repeat (2) step();

    // Reset mid-operation drops the in-flight read and clears state.
    rd_en = 1'b1; rd_addr = AW'(2*4); rst = 1'b0;
    step();
    rd_en = 1'b0;
    step();
    chk("irq_mid_reset", ovf_irq, 0);
    rst = 1'b1;
    step();
    rd_cnt(2, 64'd0);
    rd(2, 1, 64'd0);

    repeat (3) step();
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
